// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, requester state encoding and the
// default PREADY timeout.
package apb_pkg;

   localparam int ADDR_WIDTH          = 32;
   localparam int DATA_WIDTH          = 32;
   localparam int APB_TIMEOUT_DEFAULT = 16;

   // Requester transfer phases. IDLE is the only state that takes a command.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_req_state_e;

   // Width of the completer-index field in the address. A single completer
   // still gets a 1-bit field so that no zero-width slice is ever formed.
   function automatic int sel_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : apb_pkg

// File: rtl/apb_slave_decoder.sv
// Address to completer-select decoder. Purely combinational so that both
// the requester and an interconnect can reuse it.
module apb_slave_decoder
   import apb_pkg::*;
#(
   parameter int SLV_NUM     = 4,
   parameter int SLV_SEL_LSB = 12
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [SLV_NUM-1:0]    sel_o,
   output logic                  dec_err_o
);

   localparam int IDX_W = sel_idx_width(SLV_NUM);

   logic [IDX_W-1:0] idx;

   assign idx = addr_i[SLV_SEL_LSB +: IDX_W];

   // One-hot select; an index with no matching completer is a decode error.
   always_comb begin
      sel_o = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         sel_o[i] = (idx == IDX_W'(i));
      end
      dec_err_o = ~(|sel_o);
   end

endmodule : apb_slave_decoder

// File: rtl/apb_requester.sv
// APB requester: takes single read/write commands on a valid/ready port,
// runs SETUP/ACCESS transfers, and reports data or an error as a one-cycle
// response pulse. A PREADY timeout prevents a missing completer from
// stalling the command side.
//
// Command handshake: a command transfers on a PCLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends on the state only, so the
// requester never combinationally reacts to cmd_valid. The response side
// has no backpressure: rsp_valid is a single-cycle pulse.
module apb_requester
   import apb_pkg::*;
#(
   parameter int SLV_NUM        = 4,
   parameter int SLV_SEL_LSB    = 12,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response port
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   // APB bus
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic [SLV_NUM-1:0]    PSEL,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   // debug view of the transfer FSM
   output apb_req_state_e        dbg_state_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   apb_req_state_e        state_q, state_d;
   logic [SLV_NUM-1:0]    sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [SLV_NUM-1:0]    dec_sel;
   logic                  dec_err;

   apb_slave_decoder #(
      .SLV_NUM     (SLV_NUM),
      .SLV_SEL_LSB (SLV_SEL_LSB)
   ) u_dec (
      .addr_i    (cmd_addr),
      .sel_o     (dec_sel),
      .dec_err_o (dec_err)
   );

   // State, captured command, timeout counter and response registers.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Next-state logic: command capture, phase sequencing, PREADY/timeout.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               if (dec_err) begin
                  // No completer at this index: answer immediately, no bus cycle.
                  sel_d       = '0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  sel_d   = dec_sel;
                  cnt_d   = '0;
                  state_d = SETUP;
               end
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            // Only a clean 1 completes; 0, X or Z all count as not ready.
            if (PREADY == 1'b1) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            end else begin
               if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // This is the last permitted wait cycle: abort the transfer.
               if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus strobes follow the phase directly; select is held only while busy.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      PSEL      = (state_q == IDLE) ? '0 : sel_q;
      PENABLE   = (state_q == ACCESS);
   end

   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign dbg_state_o = state_q;

endmodule : apb_requester
